// File: rtl/mdr_mult_seq_ctrl_if.sv
// Handshake and shift-register control bundle for the MDR shift-and-add multiplier controller.
// The controller takes the slave modport; the surrounding datapath or bench takes master.
interface mdr_mult_seq_ctrl_if #(
    parameter int DW = 16
);
    logic            i_start;
    logic [2*DW-1:0] i_shl_val;
    logic            i_shr_lsb;
    logic            i_shr_zero;
    logic            o_shl_init;
    logic            o_shl_enable;
    logic            o_shr_init;
    logic            o_shr_enable;
    logic            o_ready;
    logic            o_done;
    logic [2*DW-1:0] o_product;

    modport slave (
        input  i_start, i_shl_val, i_shr_lsb, i_shr_zero,
        output o_shl_init, o_shl_enable, o_shr_init, o_shr_enable,
        output o_ready, o_done, o_product
    );

    modport master (
        output i_start, i_shl_val, i_shr_lsb, i_shr_zero,
        input  o_shl_init, o_shl_enable, o_shr_init, o_shr_enable,
        input  o_ready, o_done, o_product
    );
endinterface

// File: rtl/mdr_mult_seq_ctrl.sv
// Sequencer for the MDR shift-and-add unsigned multiplier: IDLE -> LOAD -> RUN (DW steps) -> DONE.
// Optional MDR_MULT_EARLY_EXIT_EN ends RUN as soon as the multiplier register has shifted to zero.
module mdr_mult_seq_ctrl #(
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst,
    mdr_mult_seq_ctrl_if.slave bus
);
    localparam int PW = 2 * DW;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
`ifdef MDR_MULT_EARLY_EXIT_EN
                if (bus.i_shr_zero) begin
                    state_d   = ST_DONE;
                    product_d = acc_q;
                end else
`endif
                begin
                    // Operands seen here are the pre-shift register values for this step.
                    if (bus.i_shr_lsb) begin
                        acc_d = acc_q + bus.i_shl_val;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_DONE;
                        product_d = acc_d;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifndef MDR_MULT_EARLY_EXIT_EN
    logic unused_shr_zero;
    assign unused_shr_zero = bus.i_shr_zero;
`endif

    // Moore outputs: decoded only from the registered state.
    assign bus.o_ready      = (state_q == ST_IDLE);
    assign bus.o_shl_init   = (state_q == ST_LOAD);
    assign bus.o_shr_init   = (state_q == ST_LOAD);
    assign bus.o_shl_enable = (state_q == ST_RUN);
    assign bus.o_shr_enable = (state_q == ST_RUN);
    assign bus.o_done       = (state_q == ST_DONE);
    assign bus.o_product    = product_q;
endmodule

// File: tb/tb_mdr_mult_seq_ctrl.sv
// Directed bench for mdr_mult_seq_ctrl (DW=8) with behavioural models of both shift registers.
// Expected done cycles follow whether MDR_MULT_EARLY_EXIT_EN is defined for the build.
module tb_mdr_mult_seq_ctrl;
    localparam int DW = 8;
`ifdef MDR_MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] prod;
        int         done_full;
        int         done_ee;
        int         pulse_cyc;
    } vec_t;

    logic clk;
    logic rst;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] shl_q;
    logic [7:0]  shr_q;
    int n_checks;
    int n_errors;

    mdr_mult_seq_ctrl_if #(.DW(DW)) bus ();

    mdr_mult_seq_ctrl #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: the two external shift registers the controller drives.
    always_ff @(posedge clk) begin
        if (bus.o_shl_init)        shl_q <= {8'h00, op_a};
        else if (bus.o_shl_enable) shl_q <= shl_q << 1;
        if (bus.o_shr_init)        shr_q <= op_b;
        else if (bus.o_shr_enable) shr_q <= shr_q >> 1;
    end

    assign bus.i_shl_val  = shl_q;
    assign bus.i_shr_lsb  = shr_q[0];
    assign bus.i_shr_zero = (shr_q == 8'h00);

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Entered at cycle 0 (IDLE, #1 after an edge); leaves 12 cycles later in IDLE.
    task automatic run_op(input vec_t v);
        int exp_done;
        int done_cnt;
        int done_cyc;
        int ready_bad;
        int init_bad;
        int en_bad;
        logic [15:0] prod_done;
        exp_done  = EE ? v.done_ee : v.done_full;
        done_cnt  = 0;
        done_cyc  = -1;
        ready_bad = 0;
        init_bad  = 0;
        en_bad    = 0;
        prod_done = '0;
        op_a = v.a;
        op_b = v.b;
        bus.i_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            bus.i_start = (k == v.pulse_cyc);
            if (bus.o_done) begin
                done_cnt++;
                done_cyc  = k;
                prod_done = bus.o_product;
            end
            if (bus.o_ready !== (k > exp_done)) ready_bad++;
            if (bus.o_shl_init !== (k == 1) || bus.o_shr_init !== (k == 1)) init_bad++;
            if (bus.o_shl_enable !== (k >= 2 && k < exp_done) ||
                bus.o_shr_enable !== (k >= 2 && k < exp_done)) en_bad++;
        end
        check({v.name, " done_count"}, done_cnt, 1);
        check({v.name, " done_cycle"}, done_cyc, exp_done);
        check({v.name, " product"}, int'(prod_done), int'(v.prod));
        check({v.name, " ready_pattern_errs"}, ready_bad, 0);
        check({v.name, " init_pattern_errs"}, init_bad, 0);
        check({v.name, " enable_pattern_errs"}, en_bad, 0);
        check({v.name, " product_held"}, int'(bus.o_product), int'(v.prod));
        $display("op %s: %0d x %0d -> product %0d, done cycle %0d (expected %0d at %0d)",
                 v.name, v.a, v.b, prod_done, done_cyc, v.prod, exp_done);
    endtask

    vec_t vecs[7];

    initial begin
        int d;
        int done_cnt;
        int first_done;
        int second_done;
        int init2_cyc;
        logic [15:0] prod2;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{"13x11",   8'd13,  8'd11,  16'd143,   10, 7,  0};
        vecs[1] = '{"255x255", 8'd255, 8'd255, 16'd65025, 10, 10, 0};
        vecs[2] = '{"0x200",   8'd0,   8'd200, 16'd0,     10, 10, 0};
        vecs[3] = '{"200x0",   8'd200, 8'd0,   16'd0,     10, 3,  0};
        vecs[4] = '{"5x3",     8'd5,   8'd3,   16'd15,    10, 5,  0};
        vecs[5] = '{"7x9_pulse", 8'd7, 8'd9,   16'd63,    10, 7,  4};
        vecs[6] = '{"6x7",     8'd6,   8'd7,   16'd42,    10, 6,  0};

        rst = 1'b0;
        bus.i_start = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", int'(bus.o_ready), 1);
        check("reset done", int'(bus.o_done), 0);
        check("reset ctrl", int'({bus.o_shl_init, bus.o_shr_init, bus.o_shl_enable, bus.o_shr_enable}), 0);
        check("reset product", int'(bus.o_product), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle after reset ready", int'(bus.o_ready), 1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i]);
        end

        // i_start held high: new LOAD one IDLE cycle after each DONE.
        d = EE ? 6 : 10;
        done_cnt = 0;
        first_done = -1;
        second_done = -1;
        init2_cyc = -1;
        prod2 = '0;
        op_a = 8'd6;
        op_b = 8'd7;
        bus.i_start = 1'b1;
        for (int k = 1; k <= 2 * d + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == d + 2) bus.i_start = 1'b0;
            if (bus.o_done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
                else begin
                    second_done = k;
                    prod2 = bus.o_product;
                end
            end
            if (bus.o_shl_init && k > 1 && init2_cyc < 0) init2_cyc = k;
        end
        check("held done_count", done_cnt, 2);
        check("held first_done", first_done, d);
        check("held reload_cycle", init2_cyc, d + 2);
        check("held second_done", second_done, 2 * d + 1);
        check("held product", int'(prod2), 42);
        $display("op held_6x7: done cycles %0d and %0d, reload cycle %0d, product %0d",
                 first_done, second_done, init2_cyc, prod2);

        // Reset asserted in cycle 5 of 13x11 aborts it with no done.
        op_a = 8'd13;
        op_b = 8'd11;
        bus.i_start = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (bus.o_done) done_cnt++;
        end
        rst = 1'b0;
        #1;
        check("abort ready", int'(bus.o_ready), 1);
        check("abort ctrl", int'({bus.o_shl_init, bus.o_shr_init, bus.o_shl_enable, bus.o_shr_enable}), 0);
        check("abort product", int'(bus.o_product), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) done_cnt++;
        end
        check("abort no_done", done_cnt, 0);
        check("abort idle ready", int'(bus.o_ready), 1);
        $display("op abort_13x11: reset in cycle 5, done pulses seen %0d", done_cnt);

        run_op(vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
